mem_refill_ctrl: RTL and testbench

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

---
 rtl/mem_refill_pkg.sv | 25 ++
 rtl/mem_refill_if.sv | 35 +++
 rtl/mem_refill_ctrl_wbuf_fifo.sv | 53 +++++
 rtl/mem_refill_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_refill_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_refill_pkg.sv
// Shared types for the data-cache refill controller: FSM states, write-buffer entry, defaults.
package mem_refill_pkg;

    localparam int WBUF_DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        FILL  = 3'd4,
        STORE = 3'd5
    } state_e;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [1:0]  lane;
        logic [7:0]  data;
    } wbuf_entry_t;

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_refill_if.sv
// Pipeline-side and memory-side signals of the refill controller in one bundle.
interface mem_refill_if;

    logic        ld_req;
    logic        st_req;
    logic [31:0] addr_in;
    logic [31:0] st_data;
    logic        cache_hit;
    logic        stall;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport master (
        input  ld_req, st_req, addr_in, st_data, cache_hit,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output stall, fill_valid, fill_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
    );

    modport slave (
        output ld_req, st_req, addr_in, st_data, cache_hit,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  stall, fill_valid, fill_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be
    );

endinterface

// File: rtl/mem_refill_ctrl_wbuf_fifo.sv
// Posted byte-store buffer (module wbuf_fifo); exists only in builds with MEM_REFILL_WBUF_EN.
`ifdef MEM_REFILL_WBUF_EN
module wbuf_fifo
    import mem_refill_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  wbuf_entry_t i_push_entry,
    input  logic        i_pop,
    output wbuf_entry_t o_head,
    output logic        o_empty,
    output logic        o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

endmodule
`endif

// File: rtl/mem_refill_ctrl.sv
// Load-miss refill and byte-store controller sharing one memory port.
// MEM_REFILL_WBUF_EN adds a posted write buffer; otherwise each store blocks in STORE.
module mem_refill_ctrl
    import mem_refill_pkg::*;
#(
    parameter int WBUF_DEPTH = WBUF_DEPTH_DEFAULT
) (
    input logic          clk,
    input logic          rst_n,
    mem_refill_if.master bus
);

    if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("WBUF_DEPTH must be a power of two >= 2");
    end

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_rsp_data;
    logic        w_miss;
    logic        w_wr_valid;
    logic [31:0] w_wr_addr;
    logic [31:0] w_wr_wdata;
    logic [3:0]  w_wr_be;
    logic        w_st_stall;

    assign w_miss = bus.ld_req && !bus.cache_hit;

`ifdef MEM_REFILL_WBUF_EN
    wbuf_entry_t w_push_entry;
    wbuf_entry_t w_head;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;

    assign w_push_entry = '{word_addr: bus.addr_in[31:2], lane: bus.addr_in[1:0], data: bus.st_data[7:0]};
    // The read FSM owns the port outside IDLE/DRAIN, so the buffer only drains there.
    assign w_wr_valid   = !w_empty && (r_state == IDLE || r_state == DRAIN);
    assign w_pop        = w_wr_valid && bus.mem_req_ready;
    assign w_wr_addr    = {w_head.word_addr, 2'b00};
    assign w_wr_be      = lane_be(w_head.lane);
    assign w_wr_wdata   = {4{w_head.data}};
    assign w_st_stall   = bus.st_req && w_full;

    wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (bus.st_req),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_full       (w_full)
    );
`else
    logic [31:0] r_st_addr;
    logic [7:0]  r_st_byte;

    always_ff @(posedge clk) begin
        if (r_state == IDLE && !w_miss && bus.st_req) begin
            r_st_addr <= bus.addr_in;
            r_st_byte <= bus.st_data[7:0];
        end
    end

    assign w_wr_valid = (r_state == STORE);
    assign w_wr_addr  = {r_st_addr[31:2], 2'b00};
    assign w_wr_be    = lane_be(r_st_addr[1:0]);
    assign w_wr_wdata = {4{r_st_byte}};
    assign w_st_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_miss)            r_addr     <= {bus.addr_in[31:2], 2'b00};
        if (r_state == WAIT && bus.mem_rsp_valid) r_rsp_data <= bus.mem_rsp_data;
    end

    // Outputs are forced low for the whole reset assertion, even with a miss on the inputs.
    always_comb begin
        w_state_nxt       = r_state;
        bus.stall         = 1'b0;
        bus.fill_valid    = 1'b0;
        bus.fill_data     = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        bus.mem_req_be    = '0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        bus.stall = 1'b1;
`ifdef MEM_REFILL_WBUF_EN
                        w_state_nxt = w_empty ? REQ : DRAIN;
`else
                        w_state_nxt = REQ;
`endif
                    end
`ifndef MEM_REFILL_WBUF_EN
                    else if (bus.st_req) w_state_nxt = STORE;
`endif
                end
                DRAIN: begin
                    bus.stall = 1'b1;
`ifdef MEM_REFILL_WBUF_EN
                    if (w_empty) w_state_nxt = REQ;
`else
                    w_state_nxt = REQ;
`endif
                end
                REQ: begin
                    bus.stall         = 1'b1;
                    bus.mem_req_valid = 1'b1;
                    bus.mem_req_addr  = r_addr;
                    if (bus.mem_req_ready) w_state_nxt = WAIT;
                end
                WAIT: begin
                    bus.stall = 1'b1;
                    if (bus.mem_rsp_valid) w_state_nxt = FILL;
                end
                FILL: begin
                    bus.stall      = 1'b1;
                    bus.fill_valid = 1'b1;
                    bus.fill_data  = r_rsp_data;
                    w_state_nxt    = IDLE;
                end
`ifndef MEM_REFILL_WBUF_EN
                STORE: begin
                    bus.stall = 1'b1;
                    if (bus.mem_req_ready) w_state_nxt = IDLE;
                end
`endif
                default: w_state_nxt = IDLE;
            endcase
            if (w_st_stall) bus.stall = 1'b1;
            if (w_wr_valid) begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_we    = 1'b1;
                bus.mem_req_addr  = w_wr_addr;
                bus.mem_req_wdata = w_wr_wdata;
                bus.mem_req_be    = w_wr_be;
            end
        end
    end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Scoreboard bench for mem_refill_ctrl; covers the STORE build by default and the
// write-buffer build when MEM_REFILL_WBUF_EN is defined.
module tb_mem_refill_ctrl;
    import mem_refill_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_fill[$];
    mem_txn_t    mon_t;
    logic [31:0] mon_d;

    mem_refill_if bus ();

    mem_refill_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic mem_txn_t wr_txn(input logic [31:0] a, input logic [7:0] d);
        mem_txn_t t;
        t.we    = 1'b1;
        t.addr  = {a[31:2], 2'b00};
        t.wdata = {d, d, d, d};
        t.be    = 4'b0001 << a[1:0];
        return t;
    endfunction

    function automatic mem_txn_t rd_txn(input logic [31:0] a);
        mem_txn_t t;
        t.we    = 1'b0;
        t.addr  = {a[31:2], 2'b00};
        t.wdata = 32'h0;
        t.be    = 4'h0;
        return t;
    endfunction

    // Monitor: every accepted memory request and every fill strobe is matched in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                check_val("mem_expected", 32'(exp_mem.size() != 0), 32'd1);
                if (exp_mem.size() != 0) begin
                    mon_t = exp_mem.pop_front();
                    check_val("mem_we",    32'(bus.mem_req_we), 32'(mon_t.we));
                    check_val("mem_addr",  bus.mem_req_addr,    mon_t.addr);
                    check_val("mem_wdata", bus.mem_req_wdata,   mon_t.wdata);
                    check_val("mem_be",    32'(bus.mem_req_be), 32'(mon_t.be));
                end
            end
            if (bus.fill_valid) begin
                check_val("fill_expected", 32'(exp_fill.size() != 0), 32'd1);
                if (exp_fill.size() != 0) begin
                    mon_d = exp_fill.pop_front();
                    check_val("fill_data", bus.fill_data, mon_d);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic settle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load miss with a responder that answers lat cycles after the read is accepted.
    task automatic run_load(input logic [31:0] a, input logic [31:0] d, input int lat,
                            output int ns, output int nf, output int sd);
        int  acc;
        logic fill_now;
        acc = -1;
        ns = 0;
        nf = 0;
        sd = 0;
        bus.ld_req    = 1'b1;
        bus.addr_in   = a;
        bus.cache_hit = 1'b0;
        exp_mem.push_back(rd_txn(a));
        exp_fill.push_back(d);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (dut.r_state == DRAIN) sd = 1;
            if (!bus.stall) break;
            ns++;
            if (bus.mem_req_valid && bus.mem_req_ready && !bus.mem_req_we) acc = c;
            fill_now = bus.fill_valid;
            if (fill_now) nf++;
            @(posedge clk);
            #1;
            bus.mem_rsp_valid = (acc >= 0 && c + 1 == acc + lat);
            bus.mem_rsp_data  = bus.mem_rsp_valid ? d : 32'h0;
            if (fill_now) bus.cache_hit = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.ld_req        = 1'b0;
        bus.cache_hit     = 1'b0;
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic issue_store(input logic [31:0] a, input logic [7:0] d, output logic stl);
        bus.st_req  = 1'b1;
        bus.addr_in = a;
        bus.st_data = {24'($urandom), d};
        exp_mem.push_back(wr_txn(a, d));
        @(negedge clk);
        stl = bus.stall;
        @(posedge clk);
        #1;
        bus.st_req = 1'b0;
    endtask

`ifndef MEM_REFILL_WBUF_EN
    // Single blocking store; ready is held low for the first 'low' stalled cycles.
    task automatic run_store(input logic [31:0] a, input logic [7:0] d, input int low,
                             output int ns, output logic stl);
        bus.mem_req_ready = (low == 0);
        issue_store(a, d, stl);
        ns = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.stall) break;
            ns++;
            @(posedge clk);
            #1;
            bus.mem_req_ready = (ns >= low);
        end
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b1;
    endtask
`endif

    int   ns, nf, sd;
    logic stl;

    initial begin
        bus.ld_req        = 1'b0;
        bus.st_req        = 1'b0;
        bus.addr_in       = 32'h0;
        bus.st_data       = 32'h0;
        bus.cache_hit     = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        settle(3);

        check_val("rst_stall",      32'(bus.stall),         32'd0);
        check_val("rst_fill_valid", 32'(bus.fill_valid),    32'd0);
        check_val("rst_fill_data",  bus.fill_data,          32'h0);
        check_val("rst_req_valid",  32'(bus.mem_req_valid), 32'd0);
        check_val("rst_req_we",     32'(bus.mem_req_we),    32'd0);
        check_val("rst_req_addr",   bus.mem_req_addr,       32'h0);
        check_val("rst_req_wdata",  bus.mem_req_wdata,      32'h0);
        check_val("rst_req_be",     32'(bus.mem_req_be),    32'd0);
        check_val("rst_state",      32'(dut.r_state),       32'(IDLE));

        rst_n = 1'b1;
        bus.mem_req_ready = 1'b1;
        settle(1);

        run_load(32'h0000_0104, 32'hDEAD_BEEF, 2, ns, nf, sd);
        check_val("ld104_stall_cycles", 32'(ns), 32'd5);
        check_val("ld104_fill_pulses",  32'(nf), 32'd1);
        check_val("ld104_no_drain",     32'(sd), 32'd0);
        settle(2);

        run_load(32'h0000_2ABE, 32'h0BAD_F00D, 1, ns, nf, sd);
        check_val("ld2abe_stall_cycles", 32'(ns), 32'd4);
        check_val("ld2abe_fill_pulses",  32'(nf), 32'd1);
        settle(2);

`ifdef MEM_REFILL_WBUF_EN
        issue_store(32'h0000_0013, 8'hA5, stl);
        exp_mem.pop_back();
        exp_mem.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hA5A5_A5A5, be: 4'b1000});
        check_val("sb13_no_stall", 32'(stl), 32'd0);
        settle(3);
        check_val("sb13_drained", 32'(exp_mem.size()), 32'd0);

        for (int i = 0; i < 4; i++) begin
            issue_store(32'h0000_0400 + 32'(i * 5), 8'(8'h30 + i), stl);
            check_val("lanes_no_stall", 32'(stl), 32'd0);
        end
        settle(4);

        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_store(32'h0000_0800 + 32'(i * 3), 8'(8'h11 * (i + 1)), stl);
            check_val("fill4_no_stall", 32'(stl), 32'd0);
        end
        bus.st_req  = 1'b1;
        bus.addr_in = 32'h0000_0823;
        bus.st_data = 32'h1234_5655;
        exp_mem.push_back(wr_txn(32'h0000_0823, 8'h55));
        @(negedge clk);
        check_val("full_stall", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check_val("full_pop_holds_stall", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("full_released", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        bus.st_req = 1'b0;
        settle(8);
        check_val("five_writes_done", 32'(exp_mem.size()), 32'd0);

        bus.mem_req_ready = 1'b0;
        issue_store(32'h0000_0C01, 8'h7E, stl);
        issue_store(32'h0000_0C06, 8'h81, stl);
        bus.mem_req_ready = 1'b1;
        run_load(32'h0000_0F00, 32'h5555_AAAA, 2, ns, nf, sd);
        check_val("drain_seen",     32'(sd), 32'd1);
        check_val("drain_ld_fills", 32'(nf), 32'd1);
        settle(2);
`else
        run_store(32'h0000_0013, 8'hA5, 0, ns, stl);
        exp_mem.push_front('{we: 1'b1, addr: 32'h10, wdata: 32'hA5A5_A5A5, be: 4'b1000});
        exp_mem.pop_back();
        check_val("sb13_no_stall",  32'(stl), 32'd0);
        check_val("sb13_one_stall", 32'(ns),  32'd1);
        check_val("sb13_written",   32'(exp_mem.size()), 32'd0);

        run_store(32'h0000_0222, 8'h3C, 3, ns, stl);
        check_val("sb_slow_stall_cycles", 32'(ns), 32'd4);
        check_val("sb_slow_written",      32'(exp_mem.size()), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_store(32'h0000_0500 + 32'(i * 5), 8'(8'hC0 + i), i % 2, ns, stl);
            check_val("lane_stall_cycles", 32'(ns), 32'((i % 2) + 1));
        end

        issue_store(32'h0000_2001, 8'h5C, stl);
        run_load(32'h0000_3008, 32'h0F0F_1234, 3, ns, nf, sd);
        check_val("st_then_ld_fills",    32'(nf), 32'd1);
        check_val("st_then_ld_no_drain", 32'(sd), 32'd0);
        settle(2);
`endif

        bus.ld_req    = 1'b1;
        bus.addr_in   = 32'h0000_0300;
        bus.cache_hit = 1'b0;
        exp_mem.push_back(rd_txn(32'h0000_0300));
        settle(2);
        check_val("wait_before_reset", 32'(dut.r_state), 32'(WAIT));
        rst_n = 1'b0;
        #1;
        check_val("rst_async_state", 32'(dut.r_state), 32'(IDLE));
        check_val("rst_async_stall", 32'(bus.stall),   32'd0);
        @(posedge clk);
        #1;
        bus.ld_req = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hCAFE_0000 + 32'(i);
            @(negedge clk);
            check_val("late_rsp_no_fill",  32'(bus.fill_valid), 32'd0);
            check_val("late_rsp_no_stall", 32'(bus.stall),      32'd0);
            @(posedge clk);
            #1;
        end
        bus.mem_rsp_valid = 1'b0;
        check_val("late_rsp_state", 32'(dut.r_state), 32'(IDLE));
        settle(3);

        check_val("mem_queue_empty",  32'(exp_mem.size()),  32'd0);
        check_val("fill_queue_empty", 32'(exp_fill.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
